// File: rtl/riscv_axi_arb2.sv
// riscv_axi_arb2: two-master (dcache=s0, icache=s1) to one-slave AXI4 arbiter
// Read and write channels each run an independent FSM with one outstanding burst.
// Responses are steered by the registered grant; IDs pass through unchanged.
// Ports: clk, rst_n (sync, active-low); sN_ar*/sN_r*/sN_aw*/sN_w*/sN_b* master
// side for N=0,1; m_* slave-side AXI4 channel set.
// Optional: define RISCV_AXI_ARB_RR_EN for per-channel round-robin arbitration,
// otherwise port 0 has fixed priority.
module riscv_axi_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_arvalid_i,
  input  logic [ADDR_W-1:0] s0_araddr_i,
  input  logic [ID_W-1:0]   s0_arid_i,
  input  logic [7:0]        s0_arlen_i,
  input  logic [1:0]        s0_arburst_i,
  output logic              s0_arready_o,
  output logic              s0_rvalid_o,
  output logic [DATA_W-1:0] s0_rdata_o,
  output logic [1:0]        s0_rresp_o,
  output logic [ID_W-1:0]   s0_rid_o,
  output logic              s0_rlast_o,
  input  logic              s0_rready_i,
  input  logic              s0_awvalid_i,
  input  logic [ADDR_W-1:0] s0_awaddr_i,
  input  logic [ID_W-1:0]   s0_awid_i,
  input  logic [7:0]        s0_awlen_i,
  input  logic [1:0]        s0_awburst_i,
  output logic              s0_awready_o,
  input  logic              s0_wvalid_i,
  input  logic [DATA_W-1:0] s0_wdata_i,
  input  logic [DATA_W/8-1:0] s0_wstrb_i,
  input  logic              s0_wlast_i,
  output logic              s0_wready_o,
  output logic              s0_bvalid_o,
  output logic [1:0]        s0_bresp_o,
  output logic [ID_W-1:0]   s0_bid_o,
  input  logic              s0_bready_i,
  input  logic              s1_arvalid_i,
  input  logic [ADDR_W-1:0] s1_araddr_i,
  input  logic [ID_W-1:0]   s1_arid_i,
  input  logic [7:0]        s1_arlen_i,
  input  logic [1:0]        s1_arburst_i,
  output logic              s1_arready_o,
  output logic              s1_rvalid_o,
  output logic [DATA_W-1:0] s1_rdata_o,
  output logic [1:0]        s1_rresp_o,
  output logic [ID_W-1:0]   s1_rid_o,
  output logic              s1_rlast_o,
  input  logic              s1_rready_i,
  input  logic              s1_awvalid_i,
  input  logic [ADDR_W-1:0] s1_awaddr_i,
  input  logic [ID_W-1:0]   s1_awid_i,
  input  logic [7:0]        s1_awlen_i,
  input  logic [1:0]        s1_awburst_i,
  output logic              s1_awready_o,
  input  logic              s1_wvalid_i,
  input  logic [DATA_W-1:0] s1_wdata_i,
  input  logic [DATA_W/8-1:0] s1_wstrb_i,
  input  logic              s1_wlast_i,
  output logic              s1_wready_o,
  output logic              s1_bvalid_o,
  output logic [1:0]        s1_bresp_o,
  output logic [ID_W-1:0]   s1_bid_o,
  input  logic              s1_bready_i,
  output logic              m_arvalid_o,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [ID_W-1:0]   m_arid_o,
  output logic [7:0]        m_arlen_o,
  output logic [1:0]        m_arburst_o,
  input  logic              m_arready_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic [ID_W-1:0]   m_rid_i,
  input  logic              m_rlast_i,
  output logic              m_rready_o,
  output logic              m_awvalid_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic [ID_W-1:0]   m_awid_o,
  output logic [7:0]        m_awlen_o,
  output logic [1:0]        m_awburst_o,
  input  logic              m_awready_i,
  output logic              m_wvalid_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic              m_wlast_o,
  input  logic              m_wready_i,
  input  logic              m_bvalid_i,
  input  logic [1:0]        m_bresp_i,
  input  logic [ID_W-1:0]   m_bid_i,
  output logic              m_bready_o
);
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_e;
  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d, rd_win, wr_win;
  logic rd_addr, rd_data, wr_addr, wr_data, wr_resp, rd_done, wr_done;
  logic r0, r1, w0, w1, b0, b1;
  assign rd_addr = rd_state_q == RD_ADDR;
  assign rd_data = rd_state_q == RD_DATA;
  assign wr_addr = wr_state_q == WR_ADDR;
  assign wr_data = wr_state_q == WR_DATA;
  assign wr_resp = wr_state_q == WR_RESP;
  assign rd_done = rd_data & m_rvalid_i & m_rready_o & m_rlast_i;
  assign wr_done = wr_resp & m_bvalid_i & m_bready_o;
`ifdef RISCV_AXI_ARB_RR_EN
  logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  assign rd_win   = (s0_arvalid_i & s1_arvalid_i) ? rd_ptr_q : s1_arvalid_i;
  assign wr_win   = (s0_awvalid_i & s1_awvalid_i) ? wr_ptr_q : s1_awvalid_i;
  // pointer hands priority to the other port once a burst finishes
  assign rd_ptr_d = rd_done ? ~rd_gnt_q : rd_ptr_q;
  assign wr_ptr_d = wr_done ? ~wr_gnt_q : wr_ptr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
`else
  assign rd_win = !s0_arvalid_i;
  assign wr_win = !s0_awvalid_i;
`endif
  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    if (rd_state_q == RD_IDLE && (s0_arvalid_i | s1_arvalid_i)) begin
      rd_state_d = RD_ADDR;
      rd_gnt_d   = rd_win;
    end
    if (rd_addr && m_arvalid_o && m_arready_i) rd_state_d = RD_DATA;
    if (rd_done) rd_state_d = RD_IDLE;
  end
  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    if (wr_state_q == WR_IDLE && (s0_awvalid_i | s1_awvalid_i)) begin
      wr_state_d = WR_ADDR;
      wr_gnt_d   = wr_win;
    end
    if (wr_addr && m_awvalid_o && m_awready_i) wr_state_d = WR_DATA;
    if (wr_data && m_wvalid_o && m_wready_i && m_wlast_o) wr_state_d = WR_RESP;
    if (wr_done) wr_state_d = WR_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
    end
  end
  assign m_arvalid_o  = rd_addr & (rd_gnt_q ? s1_arvalid_i : s0_arvalid_i);
  assign m_araddr_o   = rd_addr ? (rd_gnt_q ? s1_araddr_i : s0_araddr_i) : '0;
  assign m_arid_o     = rd_addr ? (rd_gnt_q ? s1_arid_i : s0_arid_i) : '0;
  assign m_arlen_o    = rd_addr ? (rd_gnt_q ? s1_arlen_i : s0_arlen_i) : '0;
  assign m_arburst_o  = rd_addr ? (rd_gnt_q ? s1_arburst_i : s0_arburst_i) : '0;
  assign s0_arready_o = rd_addr & !rd_gnt_q & m_arready_i;
  assign s1_arready_o = rd_addr & rd_gnt_q & m_arready_i;
  assign m_rready_o   = rd_data & (rd_gnt_q ? s1_rready_i : s0_rready_i);
  assign r0 = rd_data & !rd_gnt_q;
  assign r1 = rd_data & rd_gnt_q;
  assign s0_rvalid_o = r0 & m_rvalid_i;
  assign s0_rdata_o  = r0 ? m_rdata_i : '0;
  assign s0_rresp_o  = r0 ? m_rresp_i : '0;
  assign s0_rid_o    = r0 ? m_rid_i : '0;
  assign s0_rlast_o  = r0 & m_rlast_i;
  assign s1_rvalid_o = r1 & m_rvalid_i;
  assign s1_rdata_o  = r1 ? m_rdata_i : '0;
  assign s1_rresp_o  = r1 ? m_rresp_i : '0;
  assign s1_rid_o    = r1 ? m_rid_i : '0;
  assign s1_rlast_o  = r1 & m_rlast_i;
  assign m_awvalid_o  = wr_addr & (wr_gnt_q ? s1_awvalid_i : s0_awvalid_i);
  assign m_awaddr_o   = wr_addr ? (wr_gnt_q ? s1_awaddr_i : s0_awaddr_i) : '0;
  assign m_awid_o     = wr_addr ? (wr_gnt_q ? s1_awid_i : s0_awid_i) : '0;
  assign m_awlen_o    = wr_addr ? (wr_gnt_q ? s1_awlen_i : s0_awlen_i) : '0;
  assign m_awburst_o  = wr_addr ? (wr_gnt_q ? s1_awburst_i : s0_awburst_i) : '0;
  assign s0_awready_o = wr_addr & !wr_gnt_q & m_awready_i;
  assign s1_awready_o = wr_addr & wr_gnt_q & m_awready_i;
  // W is only opened after the AW handshake moved the FSM to WR_DATA
  assign w0 = wr_data & !wr_gnt_q;
  assign w1 = wr_data & wr_gnt_q;
  assign m_wvalid_o  = (w0 & s0_wvalid_i) | (w1 & s1_wvalid_i);
  assign m_wdata_o   = w0 ? s0_wdata_i : w1 ? s1_wdata_i : '0;
  assign m_wstrb_o   = w0 ? s0_wstrb_i : w1 ? s1_wstrb_i : '0;
  assign m_wlast_o   = (w0 & s0_wlast_i) | (w1 & s1_wlast_i);
  assign s0_wready_o = w0 & m_wready_i;
  assign s1_wready_o = w1 & m_wready_i;
  assign b0 = wr_resp & !wr_gnt_q;
  assign b1 = wr_resp & wr_gnt_q;
  assign m_bready_o  = (b0 & s0_bready_i) | (b1 & s1_bready_i);
  assign s0_bvalid_o = b0 & m_bvalid_i;
  assign s0_bresp_o  = b0 ? m_bresp_i : '0;
  assign s0_bid_o    = b0 ? m_bid_i : '0;
  assign s1_bvalid_o = b1 & m_bvalid_i;
  assign s1_bresp_o  = b1 ? m_bresp_i : '0;
  assign s1_bid_o    = b1 ? m_bid_i : '0;
endmodule

// File: tb/tb_riscv_axi_arb2.sv
// tb_riscv_axi_arb2: directed self-checking bench for riscv_axi_arb2
module tb_riscv_axi_arb2;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rlast, s0_rready;
  logic [31:0] s0_araddr, s0_rdata;
  logic [3:0] s0_arid, s0_rid;
  logic [7:0] s0_arlen;
  logic [1:0] s0_arburst, s0_rresp;
  logic s0_awvalid, s0_awready, s0_wvalid, s0_wlast, s0_wready, s0_bvalid, s0_bready;
  logic [31:0] s0_awaddr, s0_wdata;
  logic [3:0] s0_awid, s0_wstrb, s0_bid;
  logic [7:0] s0_awlen;
  logic [1:0] s0_awburst, s0_bresp;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rlast, s1_rready;
  logic [31:0] s1_araddr, s1_rdata;
  logic [3:0] s1_arid, s1_rid;
  logic [7:0] s1_arlen;
  logic [1:0] s1_arburst, s1_rresp;
  logic s1_awvalid, s1_awready, s1_wvalid, s1_wlast, s1_wready, s1_bvalid, s1_bready;
  logic [31:0] s1_awaddr, s1_wdata;
  logic [3:0] s1_awid, s1_wstrb, s1_bid;
  logic [7:0] s1_awlen;
  logic [1:0] s1_awburst, s1_bresp;
  logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0] m_arid, m_rid;
  logic [7:0] m_arlen;
  logic [1:0] m_arburst, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0] m_awid, m_wstrb, m_bid;
  logic [7:0] m_awlen;
  logic [1:0] m_awburst, m_bresp;
  int n_chk = 0;
  int n_err = 0;
  int r_cnt, w_cnt, cyc;
  bit ar_done, aw_done, b_done;

  riscv_axi_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .s0_arvalid_i(s0_arvalid), .s0_araddr_i(s0_araddr), .s0_arid_i(s0_arid), .s0_arlen_i(s0_arlen),
    .s0_arburst_i(s0_arburst), .s0_arready_o(s0_arready),
    .s0_rvalid_o(s0_rvalid), .s0_rdata_o(s0_rdata), .s0_rresp_o(s0_rresp), .s0_rid_o(s0_rid),
    .s0_rlast_o(s0_rlast), .s0_rready_i(s0_rready),
    .s0_awvalid_i(s0_awvalid), .s0_awaddr_i(s0_awaddr), .s0_awid_i(s0_awid), .s0_awlen_i(s0_awlen),
    .s0_awburst_i(s0_awburst), .s0_awready_o(s0_awready),
    .s0_wvalid_i(s0_wvalid), .s0_wdata_i(s0_wdata), .s0_wstrb_i(s0_wstrb), .s0_wlast_i(s0_wlast),
    .s0_wready_o(s0_wready), .s0_bvalid_o(s0_bvalid), .s0_bresp_o(s0_bresp), .s0_bid_o(s0_bid),
    .s0_bready_i(s0_bready),
    .s1_arvalid_i(s1_arvalid), .s1_araddr_i(s1_araddr), .s1_arid_i(s1_arid), .s1_arlen_i(s1_arlen),
    .s1_arburst_i(s1_arburst), .s1_arready_o(s1_arready),
    .s1_rvalid_o(s1_rvalid), .s1_rdata_o(s1_rdata), .s1_rresp_o(s1_rresp), .s1_rid_o(s1_rid),
    .s1_rlast_o(s1_rlast), .s1_rready_i(s1_rready),
    .s1_awvalid_i(s1_awvalid), .s1_awaddr_i(s1_awaddr), .s1_awid_i(s1_awid), .s1_awlen_i(s1_awlen),
    .s1_awburst_i(s1_awburst), .s1_awready_o(s1_awready),
    .s1_wvalid_i(s1_wvalid), .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb), .s1_wlast_i(s1_wlast),
    .s1_wready_o(s1_wready), .s1_bvalid_o(s1_bvalid), .s1_bresp_o(s1_bresp), .s1_bid_o(s1_bid),
    .s1_bready_i(s1_bready),
    .m_arvalid_o(m_arvalid), .m_araddr_o(m_araddr), .m_arid_o(m_arid), .m_arlen_o(m_arlen),
    .m_arburst_o(m_arburst), .m_arready_i(m_arready),
    .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rid_i(m_rid),
    .m_rlast_i(m_rlast), .m_rready_o(m_rready),
    .m_awvalid_o(m_awvalid), .m_awaddr_o(m_awaddr), .m_awid_o(m_awid), .m_awlen_o(m_awlen),
    .m_awburst_o(m_awburst), .m_awready_i(m_awready),
    .m_wvalid_o(m_wvalid), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wlast_o(m_wlast),
    .m_wready_i(m_wready),
    .m_bvalid_i(m_bvalid), .m_bresp_i(m_bresp), .m_bid_i(m_bid), .m_bready_o(m_bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_m_arvalid"}, 64'(m_arvalid), 0);
    chk({tag, "_m_araddr"}, 64'(m_araddr), 0);
    chk({tag, "_m_rready"}, 64'(m_rready), 0);
    chk({tag, "_m_awvalid"}, 64'(m_awvalid), 0);
    chk({tag, "_m_awaddr"}, 64'(m_awaddr), 0);
    chk({tag, "_m_wvalid"}, 64'(m_wvalid), 0);
    chk({tag, "_m_bready"}, 64'(m_bready), 0);
    chk({tag, "_s0_arready"}, 64'(s0_arready), 0);
    chk({tag, "_s1_arready"}, 64'(s1_arready), 0);
    chk({tag, "_s0_rvalid"}, 64'(s0_rvalid), 0);
    chk({tag, "_s1_rvalid"}, 64'(s1_rvalid), 0);
    chk({tag, "_s0_rdata"}, 64'(s0_rdata), 0);
    chk({tag, "_s0_wready"}, 64'(s0_wready), 0);
    chk({tag, "_s1_wready"}, 64'(s1_wready), 0);
    chk({tag, "_s0_bvalid"}, 64'(s0_bvalid), 0);
  endtask

  task automatic set_ar(input int p, input logic v, input logic [31:0] a, input logic [7:0] l,
                        input logic [3:0] id);
    if (p == 0) begin
      s0_arvalid = v; s0_araddr = a; s0_arlen = l; s0_arid = id; s0_arburst = 2'd1;
    end else begin
      s1_arvalid = v; s1_araddr = a; s1_arlen = l; s1_arid = id; s1_arburst = 2'd1;
    end
  endtask

  task automatic set_rready(input int p, input logic v);
    if (p == 0) s0_rready = v;
    else s1_rready = v;
  endtask

  // one read burst from port p with data a+beat; optional stall or reset at a given beat
  task automatic read_burst(input int p, input logic [31:0] a, input int len, input int stall_at,
                            input int stall_n, input int rst_at);
    logic [3:0] id;
    id = 4'(p + 5);
    set_ar(p, 1'b1, a, 8'(len), id);
    m_arready = 1'b1;
    set_rready(p, 1'b1);
    #2;
    chk("ar_bubble", 64'(m_arvalid), 0);
    tick();
    #2;
    chk("ar_valid", 64'(m_arvalid), 1);
    chk("ar_addr", 64'(m_araddr), 64'(a));
    chk("ar_len", 64'(m_arlen), 64'(len));
    chk("ar_id", 64'(m_arid), 64'(id));
    chk("ar_ready_gnt", 64'(p != 0 ? s1_arready : s0_arready), 1);
    chk("ar_ready_other", 64'(p != 0 ? s0_arready : s1_arready), 0);
    tick();
    set_ar(p, 1'b0, 32'h0, 8'h0, 4'h0);
    for (int i = 0; i <= len; i++) begin
      m_rvalid = 1'b1; m_rdata = a + 32'(i); m_rlast = (i == len); m_rid = id; m_rresp = 2'd0;
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        chk_idle("rst_mid");
        m_rvalid = 1'b0; m_rlast = 1'b0;
        set_rready(p, 1'b0);
        return;
      end
      if (i == stall_at) begin
        set_rready(p, 1'b0);
        for (int k = 0; k < stall_n; k++) begin
          #2;
          chk("bp_m_rready", 64'(m_rready), 0);
          chk("bp_s_rvalid", 64'(p != 0 ? s1_rvalid : s0_rvalid), 1);
          chk("bp_s_rdata", 64'(p != 0 ? s1_rdata : s0_rdata), 64'(a + 32'(i)));
          tick();
        end
        set_rready(p, 1'b1);
      end
      #2;
      chk("r_valid", 64'(p != 0 ? s1_rvalid : s0_rvalid), 1);
      chk("r_data", 64'(p != 0 ? s1_rdata : s0_rdata), 64'(a + 32'(i)));
      chk("r_last", 64'(p != 0 ? s1_rlast : s0_rlast), 64'(i == len));
      chk("r_id", 64'(p != 0 ? s1_rid : s0_rid), 64'(id));
      chk("r_other", 64'(p != 0 ? s0_rvalid : s1_rvalid), 0);
      chk("r_m_rready", 64'(m_rready), 1);
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #2;
    chk("r_end_valid", 64'(p != 0 ? s1_rvalid : s0_rvalid), 0);
    chk("r_end_rready", 64'(m_rready), 0);
  endtask

  // both ports request a len=0 read in the same cycle; exp_g is the expected winner
  task automatic contend(input logic exp_g);
    set_ar(0, 1'b1, 32'h80000100, 8'd0, 4'd1);
    set_ar(1, 1'b1, 32'h80000200, 8'd0, 4'd2);
    m_arready = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
    tick();
    #2;
    chk("cont_addr", 64'(m_araddr), exp_g ? 64'h80000200 : 64'h80000100);
    chk("cont_s0_arready", 64'(s0_arready), 64'(!exp_g));
    chk("cont_s1_arready", 64'(s1_arready), 64'(exp_g));
    tick();
    set_ar(0, 1'b0, 32'h0, 8'h0, 4'h0);
    set_ar(1, 1'b0, 32'h0, 8'h0, 4'h0);
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h55; m_rid = exp_g ? 4'd2 : 4'd1;
    #2;
    chk("cont_r_gnt", 64'(exp_g ? s1_rvalid : s0_rvalid), 1);
    chk("cont_r_other", 64'(exp_g ? s0_rvalid : s1_rvalid), 0);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_ar(0, 1'b0, 32'h0, 8'h0, 4'h0);
    set_ar(1, 1'b0, 32'h0, 8'h0, 4'h0);
    s0_rready = 0; s1_rready = 0;
    s0_awvalid = 0; s0_awaddr = 0; s0_awid = 0; s0_awlen = 0; s0_awburst = 0;
    s1_awvalid = 0; s1_awaddr = 0; s1_awid = 0; s1_awlen = 0; s1_awburst = 0;
    s0_wvalid = 0; s0_wdata = 0; s0_wstrb = 0; s0_wlast = 0; s0_bready = 0;
    s1_wvalid = 0; s1_wdata = 0; s1_wstrb = 0; s1_wlast = 0; s1_bready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rid = 0; m_rlast = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
    repeat (2) tick();
    #2;
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    // single read on the icache port
    read_burst(1, 32'h80000040, 7, -1, 0, -1);
    // simultaneous requests, twice
    contend(1'b0);
`ifdef RISCV_AXI_ARB_RR_EN
    contend(1'b1);
`else
    contend(1'b0);
`endif
    // dcache write burst; W offered early must be held off until AW completes
    s0_awvalid = 1; s0_awaddr = 32'h80001000; s0_awlen = 3; s0_awid = 4'd2; s0_awburst = 1;
    s0_wvalid = 1; s0_wdata = 32'hA5A50000; s0_wstrb = 4'hF; s0_wlast = 0;
    m_awready = 1; m_wready = 1; s0_bready = 1;
    #2;
    chk("aw_bubble", 64'(m_awvalid), 0);
    chk("w_early_ready", 64'(s0_wready), 0);
    tick();
    #2;
    chk("aw_valid", 64'(m_awvalid), 1);
    chk("aw_addr", 64'(m_awaddr), 64'h80001000);
    chk("aw_len", 64'(m_awlen), 3);
    chk("aw_ready", 64'(s0_awready), 1);
    chk("w_pre_aw_ready", 64'(s0_wready), 0);
    chk("w_pre_aw_mvalid", 64'(m_wvalid), 0);
    tick();
    s0_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      s0_wdata = 32'hA5A50000 + 32'(i); s0_wlast = (i == 3);
      #2;
      chk("w_valid", 64'(m_wvalid), 1);
      chk("w_data", 64'(m_wdata), 64'(32'hA5A50000 + 32'(i)));
      chk("w_strb", 64'(m_wstrb), 64'hF);
      chk("w_last", 64'(m_wlast), 64'(i == 3));
      chk("w_s0_ready", 64'(s0_wready), 1);
      chk("w_s1_ready", 64'(s1_wready), 0);
      tick();
    end
    s0_wvalid = 0; s0_wlast = 0;
    m_bvalid = 1; m_bresp = 0; m_bid = 4'd2;
    #2;
    chk("w_after_last", 64'(m_wvalid), 0);
    chk("b_valid", 64'(s0_bvalid), 1);
    chk("b_resp", 64'(s0_bresp), 0);
    chk("b_id", 64'(s0_bid), 2);
    chk("b_other", 64'(s1_bvalid), 0);
    chk("b_m_bready", 64'(m_bready), 1);
    tick();
    m_bvalid = 0;
    #2;
    chk("b_end", 64'(s0_bvalid), 0);
    // s1 read len=7 concurrent with s0 write len=3
    r_cnt = 0; w_cnt = 0; cyc = 0; ar_done = 0; aw_done = 0; b_done = 0;
    m_arready = 1; m_awready = 1; m_wready = 1; s1_rready = 1; s0_bready = 1;
    while (!(r_cnt == 8 && b_done) && cyc < 40) begin
      set_ar(1, !ar_done, 32'h80005000, 8'd7, 4'd6);
      s0_awvalid = !aw_done; s0_awaddr = 32'h80006000; s0_awlen = 3; s0_awid = 4'd7; s0_awburst = 1;
      m_rvalid = ar_done && r_cnt < 8; m_rdata = 32'h3000 + 32'(r_cnt); m_rlast = (r_cnt == 7); m_rid = 4'd6;
      s0_wvalid = w_cnt < 4; s0_wdata = 32'hA5A50000 + 32'(w_cnt); s0_wstrb = 4'hF; s0_wlast = (w_cnt == 3);
      m_bvalid = (w_cnt == 4) && !b_done; m_bresp = 0; m_bid = 4'd7;
      #2;
      if (m_arvalid && m_arready) ar_done = 1;
      if (m_awvalid && m_awready) aw_done = 1;
      if (m_rvalid && m_rready) begin
        chk("conc_r_data", 64'(s1_rdata), 64'(32'h3000 + 32'(r_cnt)));
        chk("conc_r_s0", 64'(s0_rvalid), 0);
        r_cnt++;
      end
      if (m_wvalid && m_wready) begin
        chk("conc_w_data", 64'(m_wdata), 64'(32'hA5A50000 + 32'(w_cnt)));
        chk("conc_w_last", 64'(m_wlast), 64'(w_cnt == 3));
        w_cnt++;
      end
      if (m_bvalid && m_bready) begin
        chk("conc_b_s0", 64'(s0_bvalid), 1);
        chk("conc_b_s1", 64'(s1_bvalid), 0);
        b_done = 1;
      end
      cyc++;
      tick();
    end
    set_ar(1, 1'b0, 32'h0, 8'h0, 4'h0);
    s0_awvalid = 0; s0_wvalid = 0; s0_wlast = 0; m_rvalid = 0; m_rlast = 0; m_bvalid = 0;
    chk("conc_done", 64'(r_cnt == 8 && b_done), 1);
    chk("conc_cycles", 64'(cyc), 10);
    // backpressure on s0 read mid-burst
    read_burst(0, 32'h80002000, 7, 3, 5, -1);
    // reset during beat 3, then a normal len=0 read
    read_burst(0, 32'h80003000, 7, -1, 0, 3);
    read_burst(1, 32'h80004000, 0, -1, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
